// File: rtl/resp_sync_fifo.sv
// resp_sync_fifo: single-clock show-ahead response FIFO with occupancy flags and sticky error flags
module resp_sync_fifo #(
    parameter int DATA_W    = 10,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     almost_full,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C   = (ADDR_W + 1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AE_C   = (ADDR_W + 1)'(AEMPTY_TH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic              wr_acc;
    logic              rd_acc;
    logic              ovf_set;
    logic              udf_set;

    // Accept decisions and flags; a write into a full FIFO is allowed only when a read frees a slot
    always_comb begin
        full         = count == FULL_C;
        empty        = count == '0;
        almost_full  = count >= AF_C;
        almost_empty = count <= AE_C;
        rd_acc       = rd_en && !flush && !empty;
        wr_acc       = wr_en && !flush && (!full || rd_acc);
        ovf_set      = wr_en && !flush && !wr_acc;
        udf_set      = rd_en && !flush && empty;
        rd_data      = empty ? '0 : mem[rptr];
    end

    // Storage array is deliberately not reset; rd_data masking keeps stale/X words off the output
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wptr] <= wr_data;
    end

    // Pointers, occupancy and sticky error flags; flush clears them synchronously
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wptr <= wptr + 1'b1;
            if (rd_acc) rptr <= rptr + 1'b1;
            if (wr_acc != rd_acc) count <= wr_acc ? count + 1'b1 : count - 1'b1;
            overflow  <= overflow | ovf_set;
            underflow <= underflow | udf_set;
        end
    end
endmodule

// File: tb/tb_resp_sync_fifo.sv
// tb_resp_sync_fifo: directed self-checking bench for resp_sync_fifo (DATA_W=10, DEPTH=16)
module tb_resp_sync_fifo;
    logic       clk = 1'b0;
    logic       resetn, flush, wr_en, rd_en;
    logic [9:0] wr_data, rd_data;
    logic       full, almost_full, empty, almost_empty, overflow, underflow;
    logic [4:0] count;
    int         checks = 0;
    int         errors = 0;

    resp_sync_fifo dut (
        .clk(clk), .resetn(resetn), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .full(full), .almost_full(almost_full),
        .empty(empty), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [9:0] d);
        wr_en = 1'b1; wr_data = d; rd_en = 1'b0;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pop;
        rd_en = 1'b1; wr_en = 1'b0;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_flush;
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset;
        logic [17:0] got, exp;
        resetn = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        #3;
        got = {count, full, almost_full, empty, almost_empty, overflow, underflow, rd_data[5:0]};
        exp = {5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0};
        checks++;
        if (got !== exp || rd_data !== 10'h000) begin
            errors++;
            $display("FAIL reset_state got=%b rd=%h exp=%b rd=000", got, rd_data, exp);
        end
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_fill_drain;
        logic [8:0] got, exp;
        for (int i = 1; i <= 16; i++) begin
            push(10'(i));
            got = {count, full, almost_full, empty, almost_empty};
            exp = {5'(i), i == 16, i >= 14, 1'b0, i <= 2};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL fill_flags n=%0d got=%b exp=%b", i, got, exp);
            end
        end
        for (int i = 1; i <= 16; i++) begin
            checks++;
            if (rd_data !== 10'(i)) begin
                errors++;
                $display("FAIL drain_data n=%0d got=%h exp=%h", i, rd_data, 10'(i));
            end
            pop();
        end
        checks++;
        if ({empty, count, rd_data} !== {1'b1, 5'd0, 10'h000}) begin
            errors++;
            $display("FAIL drain_empty got empty=%b count=%0d rd=%h exp 1/0/000", empty, count, rd_data);
        end
    endtask

    task automatic test_overflow;
        for (int i = 1; i <= 17; i++) begin
            push(10'h100 + 10'(i));
            if (i >= 16) begin
                checks++;
                if ({overflow, count} !== {i == 17, 5'd16}) begin
                    errors++;
                    $display("FAIL ovf_set n=%0d got ovf=%b count=%0d exp ovf=%b count=16", i, overflow, count, i == 17);
                end
            end
        end
        tick();
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got=%b exp=1", overflow);
        end
        for (int i = 1; i <= 16; i++) begin
            checks++;
            if (rd_data !== 10'h100 + 10'(i)) begin
                errors++;
                $display("FAIL ovf_order n=%0d got=%h exp=%h", i, rd_data, 10'h100 + 10'(i));
            end
            pop();
        end
        checks++;
        if ({overflow, empty} !== 2'b11) begin
            errors++;
            $display("FAIL ovf_after_drain got ovf=%b empty=%b exp 1/1", overflow, empty);
        end
        do_flush();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_flush got=%b exp=0", overflow);
        end
    endtask

    task automatic test_simultaneous;
        for (int i = 0; i < 16; i++) push(10'h050 + 10'(i));
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 10'h3FF;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if ({count, full, overflow, rd_data} !== {5'd16, 1'b1, 1'b0, 10'h051}) begin
            errors++;
            $display("FAIL full_both got count=%0d full=%b ovf=%b rd=%h exp 16/1/0/051", count, full, overflow, rd_data);
        end
        for (int i = 1; i <= 16; i++) begin
            checks++;
            if (rd_data !== (i == 16 ? 10'h3FF : 10'h050 + 10'(i))) begin
                errors++;
                $display("FAIL full_both_order n=%0d got=%h exp=%h", i, rd_data, i == 16 ? 10'h3FF : 10'h050 + 10'(i));
            end
            pop();
        end
        checks++;
        if ({empty, underflow} !== 2'b10) begin
            errors++;
            $display("FAIL pre_empty_both got empty=%b udf=%b exp 1/0", empty, underflow);
        end
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 10'h123;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if ({count, underflow, empty, rd_data} !== {5'd1, 1'b1, 1'b0, 10'h123}) begin
            errors++;
            $display("FAIL empty_both got count=%0d udf=%b empty=%b rd=%h exp 1/1/0/123", count, underflow, empty, rd_data);
        end
        do_flush();
        checks++;
        if ({underflow, count} !== {1'b0, 5'd0}) begin
            errors++;
            $display("FAIL udf_flush got udf=%b count=%0d exp 0/0", underflow, count);
        end
    endtask

    task automatic test_wrap;
        logic [9:0] q[$];
        for (int i = 0; i < 3; i++) begin
            push(10'h1C0 + 10'(i));
            q.push_back(10'h1C0 + 10'(i));
        end
        for (int k = 0; k < 40; k++) begin
            wr_en = 1'b1; rd_en = 1'b1; wr_data = 10'h200 + 10'(k);
            checks++;
            if (rd_data !== q[0]) begin
                errors++;
                $display("FAIL wrap_data k=%0d got=%h exp=%h", k, rd_data, q[0]);
            end
            tick();
            void'(q.pop_front());
            q.push_back(10'h200 + 10'(k));
            if (count !== 5'd3) begin
                errors++;
                $display("FAIL wrap_count k=%0d got=%0d exp=3", k, count);
            end
            checks++;
        end
        wr_en = 1'b0; rd_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_data !== q[0]) begin
                errors++;
                $display("FAIL wrap_drain n=%0d got=%h exp=%h", i, rd_data, q[0]);
            end
            void'(q.pop_front());
            pop();
        end
        checks++;
        if ({empty, overflow, underflow} !== 3'b100) begin
            errors++;
            $display("FAIL wrap_end got empty=%b ovf=%b udf=%b exp 1/0/0", empty, overflow, underflow);
        end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 16; i++) push(10'h080 + 10'(i));
        push(10'h3EE);
        for (int i = 0; i < 7; i++) pop();
        checks++;
        if ({count, overflow, rd_data} !== {5'd9, 1'b1, 10'h087}) begin
            errors++;
            $display("FAIL flush_pre got count=%0d ovf=%b rd=%h exp 9/1/087", count, overflow, rd_data);
        end
        flush = 1'b1; wr_en = 1'b1; wr_data = 10'h155;
        tick();
        flush = 1'b0; wr_en = 1'b0;
        checks++;
        if ({count, empty, overflow, rd_data} !== {5'd0, 1'b1, 1'b0, 10'h000}) begin
            errors++;
            $display("FAIL flush_clear got count=%0d empty=%b ovf=%b rd=%h exp 0/1/0/000", count, empty, overflow, rd_data);
        end
        tick();
        checks++;
        if ({count, empty} !== {5'd0, 1'b1}) begin
            errors++;
            $display("FAIL flush_nowrite got count=%0d empty=%b exp 0/1", count, empty);
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 5; i++) push(10'h0A0 + 10'(i));
        checks++;
        if (count !== 5'd5) begin
            errors++;
            $display("FAIL rst_pre got count=%0d exp=5", count);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({count, empty, rd_data} !== {5'd0, 1'b1, 10'h000}) begin
            errors++;
            $display("FAIL rst_async got count=%0d empty=%b rd=%h exp 0/1/000", count, empty, rd_data);
        end
        tick();
        #2;
        resetn = 1'b1;
        tick();
        push(10'h2AA);
        checks++;
        if ({rd_data, count, empty} !== {10'h2AA, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL rst_first_word got rd=%h count=%0d empty=%b exp 2aa/1/0", rd_data, count, empty);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_simultaneous();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/resp_sync_fifo.md
RESP_SYNC_FIFO -- requirements
Module: resp_sync_fifo

Interface
REQ-001 SHALL provide parameter DATA_W, default 10, giving the width of the stored word (ID plus response bits).
REQ-002 SHALL provide parameter DEPTH, default 16, giving the number of entries; legal values are powers of 2 from 2 to 256.
REQ-003 SHALL provide parameter AFULL_TH, default DEPTH-2, giving the occupancy at or above which almost_full asserts.
REQ-004 SHALL provide parameter AEMPTY_TH, default 2, giving the occupancy at or below which almost_empty asserts.
REQ-005 SHALL derive localparam ADDR_W = log2(DEPTH).
REQ-006 SHALL provide clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-007 SHALL provide resetn, input, width 1: asynchronous, active-low reset.
REQ-008 SHALL provide flush, input, width 1: synchronous clear of the FIFO contents and error flags.
REQ-009 SHALL provide wr_en, input, width 1: write request.
REQ-010 SHALL provide wr_data, input, width DATA_W: the write word.
REQ-011 SHALL provide rd_en, input, width 1: read request, which pops the head word.
REQ-012 SHALL provide rd_data, output, width DATA_W: the head word (show-ahead).
REQ-013 SHALL provide full, almost_full, empty and almost_empty, outputs, width 1 each: status flags.
REQ-014 SHALL provide count, output, width ADDR_W+1: current occupancy, 0..DEPTH.
REQ-015 SHALL provide overflow and underflow, outputs, width 1 each: sticky error flags.

Function
REQ-016 SHALL accept a write (wr_acc) when wr_en=1 and flush=0 and either full=0 or a read is accepted in the same cycle.
REQ-017 SHALL accept a read (rd_acc) when rd_en=1 and flush=0 and empty=0.
REQ-018 SHALL, on wr_acc, store wr_data at the write pointer and advance the write pointer modulo DEPTH.
REQ-019 SHALL, on rd_acc, advance the read pointer modulo DEPTH.
REQ-020 SHALL update count as follows: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither are accepted.
REQ-021 SHALL derive the flags combinationally from the registered count: full = (count==DEPTH); empty = (count==0); almost_full = (count>=AFULL_TH); almost_empty = (count<=AEMPTY_TH).
REQ-022 SHALL drive rd_data combinationally with mem[read pointer] when empty=0, and with all-zeros when empty=1.
REQ-023 SHALL give a word written at edge N a latency of one edge: it is visible on rd_data, with empty=0, immediately after edge N.
REQ-024 SHALL, when full=1 and wr_en=1 and rd_en=1, accept both operations; count stays at DEPTH and the new word lands in the slot being freed.
REQ-025 SHALL, when empty=1 and wr_en=1 and rd_en=1, accept only the write; count becomes 1 and underflow sets.
REQ-026 SHALL set overflow on any cycle where wr_en=1, flush=0 and the write is not accepted; the dropped data SHALL NOT alter memory or pointers.
REQ-027 SHALL set underflow on any cycle where rd_en=1, flush=0 and empty=1; pointers are unchanged.
REQ-028 SHALL hold overflow and underflow at 1 until flush or reset.
REQ-029 SHALL, on flush=1 at an edge, zero both pointers and count, clear overflow and underflow, and ignore wr_en and rd_en in that cycle; memory contents are not cleared.
REQ-030 SHALL wrap pointers from DEPTH-1 to 0 with no gap or duplicated entry.

Reset
REQ-031 SHALL, while resetn=0, asynchronously force both pointers to 0, count to 0, overflow to 0 and underflow to 0.
REQ-032 SHALL, during reset, present empty=1, almost_empty=1, full=0, almost_full=0 and rd_data=0.
REQ-033 SHALL NOT reset the memory array; rd_data masking keeps X off the output.
REQ-034 SHALL, on reset asserted mid-operation, discard all stored words; the first write after release is the first word read.

Verification (DATA_W=10, DEPTH=16, default thresholds)
REQ-035 SHALL cover fill and drain: write 0x001..0x010 -> full=1 and almost_full=1 at count 14; then read 16 -> data 0x001..0x010 in order, then empty=1 and rd_data=0.
REQ-036 SHALL cover overflow: write 17 words with no reads -> the 17th is dropped, overflow=1 sticky, count=16, and the read-back order is unchanged.
REQ-037 SHALL cover simultaneous operations at the boundaries: full with wr_en=rd_en=1 writing 0x3FF -> count stays 16 and 0x3FF is read last; empty with both asserted -> count=1 and underflow=1.
REQ-038 SHALL cover wrap: 40 interleaved write/read pairs at count 3 -> all data matches, and the pointers wrap twice.
REQ-039 SHALL cover flush: at count 9 with overflow=1, pulse flush with wr_en=1 -> next cycle count=0, empty=1, overflow=0, and nothing is written.
REQ-040 SHALL cover reset: resetn low at count 5 -> count=0 and empty=1 immediately; after release, write 0x2AA -> rd_data=0x2AA after one edge.
